// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, reset PC / NOP defaults and fetch FSM encoding.
package pc_fetch_unit_pkg;

    localparam int          WORD_W         = 32;
    localparam logic [31:0] RESET_PC_DFLT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DFLT = 32'h0000_0000;

    typedef enum logic {
        FETCH_ST_RUN  = 1'b0,
        FETCH_ST_PEND = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: stall-enabled, async-reset holder of {pc_d, pc8_d, instr_d, exc_adel}.
module pc_fetch_unit_if_id_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DFLT,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] pc8_in,
    input  logic [WORD_W-1:0] instr_in,
    input  logic              exc_in,
    output logic [WORD_W-1:0] pc_d,
    output logic [WORD_W-1:0] pc8_d,
    output logic [WORD_W-1:0] instr_d,
    output logic              exc_adel
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_d     <= RESET_PC;
            pc8_d    <= RESET_PC + 32'd8;
            instr_d  <= NOP_INSTR;
            exc_adel <= 1'b0;
        end else if (load) begin
            pc_d     <= pc_in;
            pc8_d    <= pc8_in;
            instr_d  <= instr_in;
            exc_adel <= exc_in;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns PC, drives instruction memory, replays redirects captured during stalls.
// Optional misaligned-fetch detection is enabled by defining FETCH_ALIGN_CHECK_EN.
//
//  state         | meaning
//  --------------+---------------------------------------------
//  FETCH_ST_RUN  | no redirect held; next PC is npc or pc + 4
//  FETCH_ST_PEND | a redirect arrived while stalled; target in pend_pc
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DFLT,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] npc,
    output logic [WORD_W-1:0] im_addr,
    input  logic [WORD_W-1:0] im_rdata,
    output logic [WORD_W-1:0] pc_d,
    output logic [WORD_W-1:0] pc8_d,
    output logic [WORD_W-1:0] instr_d,
    output logic              exc_adel
);

    fetch_state_t      state, state_nxt;
    logic [WORD_W-1:0] pc, pc_nxt;
    logic [WORD_W-1:0] pend_pc, pend_pc_nxt;
    logic [WORD_W-1:0] instr_in;
    logic              exc_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH_ST_RUN;
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    // A fresh redirect outranks a held one; the delay-slot instruction in IF is never squashed.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_pc_nxt = pend_pc;
        if (!stall) begin
            if (redirect)
                pc_nxt = npc;
            else if (state == FETCH_ST_PEND)
                pc_nxt = pend_pc;
            else
                pc_nxt = pc + 32'd4;
            state_nxt = FETCH_ST_RUN;
        end else if (redirect) begin
            pend_pc_nxt = npc;
            state_nxt   = FETCH_ST_PEND;
        end
    end

    assign im_addr = pc;

`ifdef FETCH_ALIGN_CHECK_EN
    always_comb begin
        exc_in   = (pc[1:0] != 2'b00);
        instr_in = exc_in ? NOP_INSTR : im_rdata;
    end
`else
    always_comb begin
        exc_in   = 1'b0;
        instr_in = im_rdata;
    end
`endif

    pc_fetch_unit_if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (!stall),
        .pc_in    (pc),
        .pc8_in   (pc + 32'd8),
        .instr_in (instr_in),
        .exc_in   (exc_in),
        .pc_d     (pc_d),
        .pc8_d    (pc8_d),
        .instr_d  (instr_d),
        .exc_adel (exc_adel)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, corner sequences, randomized model compare.
module tb_pc_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] npc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic [31:0] instr_d;
    logic        exc_adel;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_unit dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .redirect (redirect),
        .npc      (npc),
        .im_addr  (im_addr),
        .im_rdata (im_rdata),
        .pc_d     (pc_d),
        .pc8_d    (pc8_d),
        .instr_d  (instr_d),
        .exc_adel (exc_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    always_comb im_rdata = mem(im_addr);

    // Reference model: architectural PC plus a list of targets seen during the current stall.
    logic [31:0] m_pc, m_pcd, m_pc8, m_instr;
    logic        m_exc;
    logic [31:0] pend_q[$];

    task automatic model_reset();
        m_pc    = 32'h3000;
        m_pcd   = 32'h3000;
        m_pc8   = 32'h3008;
        m_instr = 32'h0;
        m_exc   = 1'b0;
        pend_q.delete();
    endtask

    task automatic model_edge(input logic st, input logic rd, input logic [31:0] n);
        bit fault;
        if (!st) begin
            fault   = ALIGN && (m_pc % 4 != 0);
            m_pcd   = m_pc;
            m_pc8   = m_pc + 8;
            m_instr = fault ? 32'h0 : mem(m_pc);
            m_exc   = fault;
            if (rd)                   m_pc = n;
            else if (pend_q.size > 0) m_pc = pend_q[pend_q.size-1];
            else                      m_pc = m_pc + 4;
            pend_q.delete();
        end else if (rd) begin
            pend_q.push_back(n);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " im_addr"}, im_addr, m_pc);
        chk({tag, " pc_d"},    pc_d,    m_pcd);
        chk({tag, " pc8_d"},   pc8_d,   m_pc8);
        chk({tag, " instr_d"}, instr_d, m_instr);
        chk({tag, " exc_adel"}, {31'b0, exc_adel}, {31'b0, m_exc});
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit after the edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] n);
        stall    = st;
        redirect = rd;
        npc      = n;
        @(posedge clk);
        #1;
        model_edge(st, rd, n);
        stall    = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst im_addr", im_addr, 32'h3000);
        chk("rst instr_d", instr_d, 32'h0);
        chk("rst pc_d",    pc_d,    32'h3000);
        chk("rst pc8_d",   pc8_d,   32'h3008);
        chk("rst exc_adel", {31'b0, exc_adel}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] n;
        logic [31:0] e_addr;
        logic [31:0] e_pcd;
        logic [31:0] e_pc8;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h0,    32'h3004, 32'h3000, 32'h3008};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,    32'h3008, 32'h3004, 32'h300C};
        tbl[2]  = '{1'b0, 1'b1, 32'h3100, 32'h3100, 32'h3008, 32'h3010};
        tbl[3]  = '{1'b1, 1'b1, 32'h3200, 32'h3100, 32'h3008, 32'h3010};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,    32'h3100, 32'h3008, 32'h3010};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,    32'h3100, 32'h3008, 32'h3010};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,    32'h3200, 32'h3100, 32'h3108};
        tbl[7]  = '{1'b1, 1'b1, 32'h3300, 32'h3200, 32'h3100, 32'h3108};
        tbl[8]  = '{1'b1, 1'b1, 32'h3400, 32'h3200, 32'h3100, 32'h3108};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,    32'h3400, 32'h3200, 32'h3208};
        tbl[10] = '{1'b1, 1'b1, 32'h3500, 32'h3400, 32'h3200, 32'h3208};
        tbl[11] = '{1'b0, 1'b1, 32'h3600, 32'h3600, 32'h3400, 32'h3408};
        tbl[12] = '{1'b0, 1'b0, 32'h0,    32'h3604, 32'h3600, 32'h3608};

        stall    = 1'b0;
        redirect = 1'b0;
        npc      = 32'h0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].st, tbl[i].rd, tbl[i].n);
            chk($sformatf("tbl%0d im_addr", i), im_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d pc_d", i),    pc_d,    tbl[i].e_pcd);
            chk($sformatf("tbl%0d pc8_d", i),   pc8_d,   tbl[i].e_pc8);
            chk($sformatf("tbl%0d instr_d", i), instr_d, mem(tbl[i].e_pcd));
        end

        // Reset mid-operation with a captured redirect outstanding: it must be discarded.
        step(1'b1, 1'b1, 32'h7000);
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        chk("rst2 im_addr0", im_addr, 32'h3004);
        chk("rst2 pc_d0",    pc_d,    32'h3000);
        step(1'b0, 1'b0, 32'h0);
        chk("rst2 im_addr1", im_addr, 32'h3008);

        // 32-bit wrap of pc + 4 and pc + 8.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap im_addr0", im_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap im_addr1", im_addr, 32'h0000_0000);
        chk("wrap pc_d",     pc_d,    32'hFFFF_FFFC);
        chk("wrap pc8_d",    pc8_d,   32'h0000_0004);

        // Misaligned fetch target taken verbatim.
        step(1'b0, 1'b1, 32'h3002);
        chk("mis im_addr", im_addr, 32'h3002);
        step(1'b0, 1'b0, 32'h0);
        chk("mis im_next", im_addr, 32'h3006);
        chk("mis pc_d",    pc_d,    32'h3002);
        chk("mis instr_d", instr_d, ALIGN ? 32'h0 : mem(32'h3002));
        chk("mis exc_adel", {31'b0, exc_adel}, {31'b0, ALIGN});

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic        st, rd;
            logic [31:0] n;
            st = ($urandom_range(0, 9) < 4);
            rd = ($urandom_range(0, 9) < 3);
            n  = $urandom;
            if ($urandom_range(0, 7) != 0) n[1:0] = 2'b00;
            step(st, rd, n);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
